// File: rtl/mod_arith_pkg.sv
// Shared types and default constants for the modular-arithmetic blocks.
// Default modulus is 3^11 on an 18-bit residue word.
package mod_arith_pkg;

  localparam int DEF_DATA_WIDTH = 18;
  localparam int DEF_MODULUS    = 177147;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_dbl_add.sv
// One MSB-first modular multiply step: acc_next = (2*acc [+ x]) mod M.
// Both operands must already be reduced below MODULUS.
module mod_dbl_add
  import mod_arith_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MODULUS    = DEF_MODULUS
) (
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic                  k_bit,
  output logic [DATA_WIDTH-1:0] acc_next
);

  localparam logic [DATA_WIDTH:0] M_EXT = (DATA_WIDTH+1)'(MODULUS);

  logic [DATA_WIDTH:0]   dbl;
  logic [DATA_WIDTH-1:0] dbl_red;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] sum_red;

  // Each partial result is < 2M, so one conditional subtract fully reduces it.
  always_comb begin
    dbl      = {acc, 1'b0};
    dbl_red  = DATA_WIDTH'((dbl >= M_EXT) ? dbl - M_EXT : dbl);
    sum      = {1'b0, dbl_red} + {1'b0, x};
    sum_red  = DATA_WIDTH'((sum >= M_EXT) ? sum - M_EXT : sum);
    acc_next = k_bit ? sum_red : dbl_red;
  end

endmodule

// File: rtl/mod_div_c_seq.sv
// Sequential divide-by-constant mod M: out_data = in_data * CONST_INV mod MODULUS,
// computed one CONST_INV bit per cycle, MSB first.
module mod_div_c_seq
  import mod_arith_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MODULUS    = DEF_MODULUS,
  parameter int CONST_INV  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output state_e                dbg_state
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DATA_WIDTH-1:0] C_VEC = DATA_WIDTH'(CONST_INV);
  localparam logic [DATA_WIDTH-1:0] M_VEC = DATA_WIDTH'(MODULUS);

  state_e                state;
  logic [DATA_WIDTH-1:0] x_reg;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [IW-1:0]         bit_idx;
  logic                  fin;

  assign dbg_state = state;

  mod_dbl_add #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODULUS    (MODULUS)
  ) u_step (
    .acc      (acc),
    .x        (x_reg),
    .k_bit    (C_VEC[bit_idx]),
    .acc_next (acc_next)
  );

  // Handshakes: a word moves on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE; out_valid only in DONE, with data/err held
  // stable until out_ready takes the result. No same-cycle bypass between them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      x_reg     <= '0;
      acc       <= '0;
      bit_idx   <= '0;
      fin       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg    <= in_data;
            acc      <= '0;
            bit_idx  <= IW'(DATA_WIDTH - 1);
            fin      <= 1'b0;
            in_ready <= 1'b0;
            if (in_data >= M_VEC) begin
              out_data  <= '0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // The cycle after the bit-0 step moves the final accumulator out.
          if (fin) begin
            out_data  <= acc;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            acc <= acc_next;
            if (bit_idx == '0) begin
              fin <= 1'b1;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mod_div_c_seq.md
MOD_DIV_C_SEQ -- requirements
Module: mod_div_c_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, residue word width.
REQ-002 SHALL have parameter MODULUS, default 177147, modulus M; MODULUS < 2^DATA_WIDTH.
REQ-003 SHALL have parameter CONST_INV, default 1, precomputed C^-1 mod M; CONST_INV < MODULUS.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  operand X valid.
REQ-007 SHALL have port in_ready  output  1  block can accept X.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  operand X.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  result X*CONST_INV mod M, i.e. X divided by C mod M.
REQ-012 SHALL have port out_err  output  1  X was out of range, qualified by out_valid.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1; on in_valid, latch X, clear accumulator, set bit index to DATA_WIDTH-1, go to RUN.
REQ-015 If latched X >= MODULUS, SHALL skip RUN and go directly to DONE with out_data=0, out_err=1.
REQ-016 RUN: one step per cycle, MSB first over CONST_INV: acc = 2*acc mod M; if CONST_INV[i]=1, acc = acc + X mod M.
REQ-017 Each step SHALL use DATA_WIDTH+1-bit intermediates; each reduction is a single conditional subtract of M (operands always < M).
REQ-018 After the step for bit 0, SHALL go to DONE; in-range latency is accept cycle + DATA_WIDTH cycles, so out_valid rises DATA_WIDTH+1 cycles after the accept edge.
REQ-019 DONE: out_valid=1, out_data and out_err held stable until out_ready=1; then go to IDLE.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there, and in_data changes have no effect after the accept edge.
REQ-021 Result SHALL be taken in DONE when out_valid and out_ready are high on the same edge; in_ready rises the next cycle. No same-cycle bypass.
REQ-022 X=0 or CONST_INV=0 SHALL give out_data=0, out_err=0, with full latency.
REQ-023 out_data SHALL always be < MODULUS.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, in_ready=1 after reset, out_valid=0, out_data=0, out_err=0, and clear the accumulator and bit index.
REQ-025 Reset during RUN or DONE SHALL discard the operation in flight without emitting a result.

Structure
REQ-026 The FSM state enum and the default DATA_WIDTH/MODULUS constants SHALL live in shared package mod_arith_pkg.
REQ-027 The double-and-conditional-add step SHALL be one combinational sub-module, mod_dbl_add (inputs acc, X, bit; output next acc).
REQ-028 Output registers SHALL be flops; no LUT/ROM is used.

Verification (MODULUS=177147, CONST_INV=88574 = 2^-1 mod M, DATA_WIDTH=18)
REQ-029 X=10 accepted -> out_valid 19 cycles later, out_data=5, out_err=0.
REQ-030 X=177146 -> out_data=88573; X=1 -> out_data=88574.
REQ-031 X=200000 -> out_valid on the cycle after accept, out_data=0, out_err=1.
REQ-032 out_ready held 0 for 5 cycles in DONE -> out_data stable, in_ready=0 throughout; in_valid pulses ignored.
REQ-033 rst_n=0 for one cycle at RUN step 7 -> no out_valid; in_ready=1 next cycle; new X=4 -> out_data=2.
REQ-034 Random back-to-back X in [0,M) with random out_ready -> every result matches (X*88574) mod 177147, in order, none dropped.
